// File: rtl/seq_shifter.sv
// Multi-mode iterative shifter (SLL/SRL/SRA/ROL/ROR), STEP bit positions per clock.
// Latency: out_valid rises 1+ceil(eff/STEP) edges after accept, where the accept edge counts as the first.
// Backpressure: in_ready only in IDLE; the result is held in DONE until out_ready is seen at an edge.
// Ports:
//   clk, rst_n             rising-edge clock, synchronous active-low reset
//   in_valid/in_ready      request handshake; in_data operand, in_shamt amount, in_mode op
//   out_valid/out_ready    result handshake; out_data, out_carry (last bit out), out_zero
//   busy                   high whenever the block is not idle
module seq_shifter #(
  parameter int WIDTH   = 8,
  parameter int SHAMT_W = 5,
  parameter int STEP    = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_data,
  input  logic [SHAMT_W-1:0] in_shamt,
  input  logic [2:0]         in_mode,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   out_data,
  output logic               out_carry,
  output logic               out_zero,
  output logic               busy
);

  // Count register must hold WIDTH itself (SLL/SRL/SRA saturate at WIDTH).
  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] STEP_C = CNT_W'(STEP);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  typedef enum logic [2:0] {
    MODE_SLL = 3'd0,
    MODE_SRL = 3'd1,
    MODE_SRA = 3'd2,
    MODE_ROL = 3'd3,
    MODE_ROR = 3'd4
  } mode_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   data_q, data_d;
  logic [2:0]         mode_q, mode_d;
  logic [CNT_W-1:0]   rem_q, rem_d;
  logic               carry_q, carry_d;
  logic               zero_q, zero_d;

  logic [CNT_W-1:0]   eff;
  logic [CNT_W-1:0]   k;
  logic [WIDTH:0]     wide;
  logic [2*WIDTH-1:0] dd;
  logic [WIDTH-1:0]   step_data;
  logic               step_carry;

  // Effective shift count of the incoming request.
  always_comb begin
    eff = '0;
    case (in_mode)
      MODE_SLL, MODE_SRL, MODE_SRA:
        eff = (32'(in_shamt) >= WIDTH) ? CNT_W'(WIDTH) : CNT_W'(in_shamt);
      MODE_ROL, MODE_ROR:
        eff = CNT_W'(32'(in_shamt) % WIDTH);
      default: eff = '0;
    endcase
  end

  // One SHIFT step by k = min(STEP, remaining).
  // Shifts carry one extra guard bit so the last bit shifted out lands in it;
  // rotates shift a doubled copy and take the relevant half.
  // For SRA the stored MSB stays the original sign, so >>> fills correctly.
  always_comb begin
    k          = (rem_q < STEP_C) ? rem_q : STEP_C;
    wide       = '0;
    dd         = '0;
    step_data  = data_q;
    step_carry = carry_q;
    case (mode_q)
      MODE_SLL: begin
        wide       = {1'b0, data_q} << k;
        step_data  = wide[WIDTH-1:0];
        step_carry = wide[WIDTH];
      end
      MODE_SRL: begin
        wide       = {data_q, 1'b0} >> k;
        step_data  = wide[WIDTH:1];
        step_carry = wide[0];
      end
      MODE_SRA: begin
        wide       = $signed({data_q, 1'b0}) >>> k;
        step_data  = wide[WIDTH:1];
        step_carry = wide[0];
      end
      MODE_ROL: begin
        dd         = {data_q, data_q} << k;
        step_data  = dd[2*WIDTH-1:WIDTH];
        step_carry = dd[WIDTH];
      end
      MODE_ROR: begin
        dd         = {data_q, data_q} >> k;
        step_data  = dd[WIDTH-1:0];
        step_carry = dd[WIDTH-1];
      end
      default: begin
        step_data  = data_q;
        step_carry = carry_q;
      end
    endcase
  end

  // Next-state and datapath update.
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    mode_d  = mode_q;
    rem_d   = rem_q;
    carry_d = carry_q;
    zero_d  = zero_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          data_d  = in_data;
          mode_d  = in_mode;
          rem_d   = eff;
          carry_d = 1'b0;
          zero_d  = (in_data == '0);
          state_d = (eff != '0) ? SHIFT : DONE;
        end
      end
      SHIFT: begin
        data_d  = step_data;
        carry_d = step_carry;
        zero_d  = (step_data == '0);
        rem_d   = rem_q - k;
        if (rem_q == k) begin
          state_d = DONE;
        end
      end
      DONE: begin
        // Handoff edge returns to IDLE only; in_valid is not looked at here.
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      data_q  <= '0;
      mode_q  <= '0;
      rem_q   <= '0;
      carry_q <= 1'b0;
      zero_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      mode_q  <= mode_d;
      rem_q   <= rem_d;
      carry_q <= carry_d;
      zero_q  <= zero_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign out_data  = data_q;
  assign out_carry = carry_q;
  assign out_zero  = zero_q;

endmodule

// File: tb/tb_seq_shifter.sv
module tb_seq_shifter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic [7:0] in_data;
  logic [4:0] in_shamt;
  logic [2:0] in_mode;
  logic       out_ready;

  logic       ir1, ov1, oc1, oz1, bz1;
  logic [7:0] od1;
  logic       ir4, ov4, oc4, oz4, bz4;
  logic [7:0] od4;

  int checks = 0;
  int errors = 0;

  // Results of the most recent run_op, per instance.
  logic [7:0] r1_d, r4_d;
  logic       r1_c, r4_c, r1_z, r4_z;
  int         l1, l4;

  always #5 clk = ~clk;

  seq_shifter #(.WIDTH(8), .SHAMT_W(5), .STEP(1)) u1 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(ir1), .in_data(in_data), .in_shamt(in_shamt), .in_mode(in_mode),
    .out_valid(ov1), .out_ready(out_ready), .out_data(od1), .out_carry(oc1), .out_zero(oz1),
    .busy(bz1)
  );

  seq_shifter #(.WIDTH(8), .SHAMT_W(5), .STEP(4)) u4 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(ir4), .in_data(in_data), .in_shamt(in_shamt), .in_mode(in_mode),
    .out_valid(ov4), .out_ready(out_ready), .out_data(od4), .out_carry(oc4), .out_zero(oz4),
    .busy(bz4)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: whole-value arithmetic on an 8-bit operand.
  function automatic void model(input logic [7:0] d, input int sh, input int mode, input int step,
                                output logic [7:0] res, output logic c, output int lat);
    int eff;
    int v;
    int sv;
    v   = int'(d);
    sv  = (v >= 128) ? v - 256 : v;
    res = d;
    c   = 1'b0;
    if (mode <= 2)      eff = (sh > 8) ? 8 : sh;
    else if (mode <= 4) eff = sh % 8;
    else                eff = 0;
    case (mode)
      0: begin res = 8'((v << eff) & 255);            c = (eff > 0) && (((v >> (8 - eff)) & 1) != 0); end
      1: begin res = 8'(v >> eff);                    c = (eff > 0) && (((v >> (eff - 1)) & 1) != 0); end
      2: begin res = 8'(sv >>> eff);                  c = (eff > 0) && (((sv >>> (eff - 1)) & 1) != 0); end
      3: begin res = 8'((v << eff) | (v >> (8 - eff))); c = (eff > 0) && res[0]; end
      4: begin res = 8'((v >> eff) | (v << (8 - eff))); c = (eff > 0) && res[7]; end
      default: begin res = d; c = 1'b0; end
    endcase
    lat = 1 + (eff + step - 1) / step;
  endfunction

  // Issue one request to both instances, collect each result, compare with the model.
  // Latency counts the accept edge as edge 1.
  task automatic run_op(input logic [7:0] d, input logic [4:0] sh, input logic [2:0] m);
    logic [7:0] e_d1, e_d4;
    logic       e_c1, e_c4;
    int         e_l1, e_l4;
    int         cyc;
    bit         g1, g4;
    model(d, int'(sh), int'(m), 1, e_d1, e_c1, e_l1);
    model(d, int'(sh), int'(m), 4, e_d4, e_c4, e_l4);
    in_data   = d;
    in_shamt  = sh;
    in_mode   = m;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    cyc = 1; g1 = 0; g4 = 0;
    l1 = -1; l4 = -1;
    while (cyc < 100) begin
      if (!g1 && ov1) begin g1 = 1; l1 = cyc; r1_d = od1; r1_c = oc1; r1_z = oz1; end
      if (!g4 && ov4) begin g4 = 1; l4 = cyc; r4_d = od4; r4_c = oc4; r4_z = oz4; end
      if (g1 && g4) break;
      @(posedge clk); #1;
      cyc++;
    end
    check("done_in_time", {30'd0, g1, g4}, 32'd3);
    @(posedge clk); #1;
    check("idle_after_handoff", {30'd0, ir1, ir4}, 32'd3);
    if (g1 && g4) begin
      check("data_s1", r1_d, e_d1);
      check("carry_s1", r1_c, e_c1);
      check("zero_s1", r1_z, (e_d1 == 8'd0));
      check("lat_s1", l1, e_l1);
      check("data_s4", r4_d, e_d4);
      check("carry_s4", r4_c, e_c4);
      check("zero_s4", r4_z, (e_d4 == 8'd0));
      check("lat_s4", l4, e_l4);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    int  cyc;
    bit  got;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_data = '0; in_shamt = '0; in_mode = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", {30'd0, ir1, ir4}, 32'd3);
    check("rst_out_valid", {30'd0, ov1, ov4}, 32'd0);
    check("rst_busy", {30'd0, bz1, bz4}, 32'd0);
    check("rst_data", {od1, od4}, 32'd0);
    check("rst_flags", {oc1, oz1, oc4, oz4}, 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed examples with constant expectations.
    run_op(8'h81, 5'd1, 3'd0);
    check("sll81_data", r1_d, 8'h02); check("sll81_carry", r1_c, 1'b1);
    check("sll81_zero", r1_z, 1'b0);  check("sll81_lat", l1, 2);
    run_op(8'h90, 5'd3, 3'd2);
    check("sra90_data", r1_d, 8'hF2); check("sra90_carry", r1_c, 1'b0); check("sra90_lat", l1, 4);
    run_op(8'h90, 5'd3, 3'd1);
    check("srl90_data", r1_d, 8'h12);
    run_op(8'h01, 5'd9, 3'd4);
    check("ror01_data", r1_d, 8'h80); check("ror01_carry", r1_c, 1'b1);
    run_op(8'hFF, 5'd20, 3'd0);
    check("sllff_data", r1_d, 8'h00); check("sllff_zero", r1_z, 1'b1);
    check("sllff_carry", r1_c, 1'b1); check("sllff_lat", l1, 9);
    run_op(8'hA5, 5'd0, 3'd3);
    check("sh0_data", r1_d, 8'hA5); check("sh0_carry", r1_c, 1'b0); check("sh0_lat", l1, 1);
    run_op(8'h5A, 5'd7, 3'd6);
    check("rsv_data", r1_d, 8'h5A); check("rsv_carry", r1_c, 1'b0); check("rsv_lat", l1, 1);
    run_op(8'h0F, 5'd5, 3'd0);
    check("s4_data", r4_d, 8'hE0); check("s4_carry", r4_c, 1'b1); check("s4_lat", l4, 3);
    run_op(8'h80, 5'd31, 3'd2);
    check("sra_sat_data", r1_d, 8'hFF); check("sra_sat_carry", r1_c, 1'b1);

    // Hold result in DONE with out_ready low while in_valid pulses.
    in_data = 8'h81; in_shamt = 5'd1; in_mode = 3'd0; out_ready = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    got = 0;
    for (cyc = 0; cyc < 20; cyc++) begin
      if (ov1) begin got = 1; break; end
      @(posedge clk); #1;
    end
    check("hold_reached_done", got, 1'b1);
    for (int i = 0; i < 5; i++) begin
      in_valid = i[0];
      in_data  = 8'($urandom);
      in_shamt = 5'($urandom);
      in_mode  = 3'($urandom);
      @(posedge clk); #1;
      check("hold_valid", ov1, 1'b1);
      check("hold_in_ready", ir1, 1'b0);
      check("hold_data", od1, 8'h02);
      check("hold_carry", oc1, 1'b1);
    end
    // Release while in_valid is high: handoff edge must not also accept.
    in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("release_idle", {ir1, ov1, bz1}, 3'b100);
    check("release_idle_s4", {ir4, ov4, bz4}, 3'b100);

    // Reset in the middle of a long shift.
    in_data = 8'hFF; in_shamt = 5'd20; in_mode = 3'd0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("midshift_busy", bz1, 1'b1);
    rst_n = 1'b0;
    @(posedge clk); #1;
    check("midrst_state", {ir1, ov1, bz1}, 3'b100);
    check("midrst_outs", {od1, oc1, oz1}, 10'd0);
    rst_n = 1'b1;
    run_op(8'h90, 5'd3, 3'd2);
    check("post_rst_data", r1_d, 8'hF2);

    // Randomised operations against the model.
    for (int n = 0; n < 40; n++) begin
      run_op(8'($urandom), 5'($urandom_range(0, 31)), 3'($urandom_range(0, 7)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
